// File: rtl/pc_npc_unit.sv
// pc_npc_unit: PC/nPC register pair for the MIPS fetch stage.
// Supports delayed branches (DELAY_SLOT=1) or immediate redirect with flush
// (DELAY_SLOT=0), stall hold with branch capture, and an exception redirect
// that overrides everything else.
module pc_npc_unit #(
    parameter int AW         = 9,
    parameter int PC_RST     = 0,
    parameter int STEP       = 4,
    parameter int DELAY_SLOT = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Stall,
    input  logic          BranchTaken,
    input  logic [AW-1:0] BranchTarget,
    input  logic          Redirect,
    input  logic [AW-1:0] RedirectAddr,
    output logic [AW-1:0] PC,
    output logic [AW-1:0] nPC,
    output logic          InDelaySlot,
    output logic          Flush,
    output logic          AlignErr
);

    localparam logic [AW-1:0] STEP_A     = AW'(STEP);
    localparam logic [AW-1:0] ALIGN_MASK = AW'(STEP - 1);
    localparam logic [AW-1:0] RST_PC     = AW'(PC_RST);
    localparam logic [AW-1:0] RST_NPC    = AW'(PC_RST + STEP);

    // PEND doubles as the "pending branch valid" flag; its target lives in ptgt_q.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_SLOT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] npc_q, npc_d;
    logic [AW-1:0] ptgt_q, ptgt_d;
    logic          ids_q, ids_d;
    logic          flush_q, flush_d;
    logic          aerr_q, aerr_d;

    logic          branch_eff;
    logic [AW-1:0] eff_tgt;

    // A captured branch takes precedence over whatever BranchTaken says on the release edge.
    always_comb begin
        branch_eff = (state_q == ST_PEND) || BranchTaken;
        eff_tgt    = (state_q == ST_PEND) ? ptgt_q : BranchTarget;
    end

    // State and datapath registers; reset discards any pending branch immediately.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_RUN;
            pc_q    <= RST_PC;
            npc_q   <= RST_NPC;
            ptgt_q  <= '0;
            ids_q   <= 1'b0;
            flush_q <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            ptgt_q  <= ptgt_d;
            ids_q   <= ids_d;
            flush_q <= flush_d;
            aerr_q  <= aerr_d;
        end
    end

    // Next-state logic: Redirect > Stall > pending/BranchTaken > sequential.
    always_comb begin
        state_d = state_q;
        if (Redirect) begin
            state_d = ST_RUN;
        end else if (Stall) begin
            if (BranchTaken) begin
                state_d = ST_PEND;
            end
        end else if (branch_eff) begin
            state_d = (DELAY_SLOT != 0) ? ST_SLOT : ST_RUN;
        end else begin
            state_d = ST_RUN;
        end
    end

    // Next PC/nPC and one-cycle pulse flags, same priority order as the FSM.
    always_comb begin
        pc_d    = pc_q;
        npc_d   = npc_q;
        ptgt_d  = ptgt_q;
        ids_d   = ids_q;
        flush_d = 1'b0;
        aerr_d  = 1'b0;
        if (Redirect) begin
            // Exception restart: alignment of RedirectAddr is not flagged here.
            pc_d    = RedirectAddr;
            npc_d   = RedirectAddr + STEP_A;
            ids_d   = 1'b0;
            flush_d = 1'b1;
        end else if (Stall) begin
            // Hold; a later capture under the same stall overwrites the earlier one.
            if (BranchTaken) begin
                ptgt_d = BranchTarget;
            end
        end else if (branch_eff) begin
            aerr_d = |(eff_tgt & ALIGN_MASK);
            if (DELAY_SLOT != 0) begin
                pc_d  = npc_q;
                npc_d = eff_tgt;
                ids_d = 1'b1;
            end else begin
                pc_d    = eff_tgt;
                npc_d   = eff_tgt + STEP_A;
                ids_d   = 1'b0;
                flush_d = 1'b1;
            end
        end else begin
            pc_d  = npc_q;
            npc_d = npc_q + STEP_A;
            ids_d = 1'b0;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        PC          = pc_q;
        nPC         = npc_q;
        InDelaySlot = ids_q;
        Flush       = flush_q;
        AlignErr    = aerr_q;
    end

endmodule

// File: tb/tb_pc_npc_unit.sv
// Testbench for pc_npc_unit: one instance per branch mode driven by shared
// stimulus; a reference model predicts each edge and a monitor compares.
module tb_pc_npc_unit;

    localparam int AW   = 9;
    localparam int STEP = 4;
    localparam int MODV = 512;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Stall = 1'b0;
    logic          BranchTaken = 1'b0;
    logic [AW-1:0] BranchTarget = '0;
    logic          Redirect = 1'b0;
    logic [AW-1:0] RedirectAddr = '0;

    logic [AW-1:0] pc0, npc0, pc1, npc1;
    logic          ids0, fl0, ae0, ids1, fl1, ae1;

    int checks = 0;
    int errors = 0;
    bit done = 0;

    always #5 Clk = ~Clk;

    pc_npc_unit #(.AW(AW), .PC_RST(0), .STEP(STEP), .DELAY_SLOT(0)) u_imm (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .Redirect(Redirect), .RedirectAddr(RedirectAddr),
        .PC(pc0), .nPC(npc0), .InDelaySlot(ids0), .Flush(fl0), .AlignErr(ae0));

    pc_npc_unit #(.AW(AW), .PC_RST(0), .STEP(STEP), .DELAY_SLOT(1)) u_dly (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .Redirect(Redirect), .RedirectAddr(RedirectAddr),
        .PC(pc1), .nPC(npc1), .InDelaySlot(ids1), .Flush(fl1), .AlignErr(ae1));

    typedef struct {
        int mode;
        int pc;
        int npc;
        bit ids;
        bit flush;
        bit aerr;
    } exp_t;

    exp_t sb[$];

    // Reference model state, index = DELAY_SLOT value of the DUT it predicts.
    int m_pc[2], m_npc[2], m_ptgt[2];
    bit m_ids[2], m_flush[2], m_aerr[2], m_pend[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic model_edge(input int m, input bit rst, input bit st, input bit bt,
                              input int tgt, input bit rd, input int ra);
        int t;
        bit have;
        m_flush[m] = 0;
        m_aerr[m]  = 0;
        if (!rst) begin
            m_pc[m] = 0; m_npc[m] = STEP; m_ids[m] = 0; m_pend[m] = 0;
        end else if (rd) begin
            m_pc[m] = ra; m_npc[m] = (ra + STEP) % MODV;
            m_flush[m] = 1; m_ids[m] = 0; m_pend[m] = 0;
        end else if (st) begin
            if (bt) begin m_pend[m] = 1; m_ptgt[m] = tgt; end
        end else begin
            have = m_pend[m] || bt;
            t = m_pend[m] ? m_ptgt[m] : tgt;
            m_pend[m] = 0;
            if (have) begin
                m_aerr[m] = (t % STEP) != 0;
                if (m == 1) begin
                    m_pc[m] = m_npc[m]; m_npc[m] = t; m_ids[m] = 1;
                end else begin
                    m_pc[m] = t; m_npc[m] = (t + STEP) % MODV; m_flush[m] = 1; m_ids[m] = 0;
                end
            end else begin
                m_pc[m] = m_npc[m]; m_npc[m] = (m_npc[m] + STEP) % MODV; m_ids[m] = 0;
            end
        end
        sb.push_back('{mode: m, pc: m_pc[m], npc: m_npc[m], ids: m_ids[m],
                       flush: m_flush[m], aerr: m_aerr[m]});
    endtask

    task automatic step(input bit rst, input bit st, input bit bt, input int tgt,
                        input bit rd, input int ra);
        logic [31:0] tv, rv;
        tv = tgt;
        rv = ra;
        @(negedge Clk);
        Reset = rst; Stall = st; BranchTaken = bt; BranchTarget = tv[AW-1:0];
        Redirect = rd; RedirectAddr = rv[AW-1:0];
        @(posedge Clk);
        for (int m = 0; m < 2; m++) model_edge(m, rst, st, bt, tgt, rd, ra);
        #1;
    endtask

    // Monitor: every edge, pop predictions and compare against the matching DUT.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.mode == 1) begin
                    chk("dly_pc", pc1, e.pc);
                    chk("dly_npc", npc1, e.npc);
                    chk("dly_ids", ids1, e.ids);
                    chk("dly_flush", fl1, e.flush);
                    chk("dly_aerr", ae1, e.aerr);
                end else begin
                    chk("imm_pc", pc0, e.pc);
                    chk("imm_npc", npc0, e.npc);
                    chk("imm_ids", ids0, e.ids);
                    chk("imm_flush", fl0, e.flush);
                    chk("imm_aerr", ae0, e.aerr);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int tgt, ra;
        bit rst, st, bt, rd;

        // Reset and count
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_pc", pc1, 32'h000);
        chk("rst_npc", npc1, 32'h004);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        chk("cnt_pc", pc1, 32'h00C);
        chk("cnt_npc", npc1, 32'h010);

        // Branch at PC=0x008 to 0x040 in both modes
        step(0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        chk("pre_br_pc", pc1, 32'h008);
        step(1, 0, 1, 32'h040, 0, 0);
        chk("dslot_pc", pc1, 32'h00C);
        chk("dslot_npc", npc1, 32'h040);
        chk("dslot_ids", ids1, 1);
        chk("imm_br_pc", pc0, 32'h040);
        chk("imm_br_flush", fl0, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("after_slot_pc", pc1, 32'h040);
        chk("after_slot_npc", npc1, 32'h044);
        chk("after_slot_ids", ids1, 0);
        chk("imm_flush_gone", fl0, 0);

        // Stall capture; the BranchTaken on the release edge must be ignored
        step(1, 1, 1, 32'h080, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("stall_hold_pc", pc1, 32'h040);
        step(1, 0, 1, 32'h0C0, 0, 0);
        chk("release_npc", npc1, 32'h080);
        chk("release_imm_pc", pc0, 32'h080);

        // Redirect beats stall and branch, and clears the pending branch
        step(1, 1, 1, 32'h060, 0, 0);
        step(1, 1, 1, 32'h1C0, 1, 32'h100);
        chk("redir_pc", pc1, 32'h100);
        chk("redir_npc", npc1, 32'h104);
        chk("redir_flush", fl1, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("redir_seq_pc", pc0, 32'h104);
        chk("redir_seq_ids", ids1, 0);

        // Asynchronous reset, sampled between edges
        @(negedge Clk);
        Reset = 0;
        #1;
        chk("async_pc", pc1, 32'h000);
        chk("async_npc", npc0, 32'h004);
        step(0, 0, 0, 0, 0, 0);

        // Wrap and misaligned target
        step(1, 0, 0, 0, 1, 32'h1F8);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc1, 32'h1FC);
        chk("wrap_npc", npc1, 32'h000);
        step(1, 0, 1, 32'h042, 0, 0);
        chk("align_dly", ae1, 1);
        chk("align_imm", ae0, 1);
        chk("align_imm_pc", pc0, 32'h042);
        step(1, 0, 0, 0, 0, 0);
        chk("align_pulse_end", ae1, 0);
        chk("align_dly_pc", pc1, 32'h042);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            st  = ($urandom_range(0, 3) == 0);
            bt  = ($urandom_range(0, 4) == 0);
            rd  = ($urandom_range(0, 24) == 0);
            tgt = ($urandom_range(0, 1) == 0) ? ($urandom_range(0, 127) * 4)
                                              : $urandom_range(0, 511);
            ra  = $urandom_range(0, 127) * 4;
            step(rst, st, bt, tgt, rd, ra);
        end

        repeat (2) @(posedge Clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
